slow_line_mem: RTL and testbench

//  Behavioural off-chip memory model with fixed multi-cycle latency and a 128-bit line interface.

---
 rtl/slow_mem_pkg.sv | 13 +
 rtl/slow_mem_lat_cnt.sv | 38 +++
 rtl/slow_line_mem.sv | 152 +++++++++++++++
 tb/tb_slow_line_mem.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/slow_mem_pkg.sv
// Shared constants and FSM state type for the slow line memory model.
package slow_mem_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/slow_mem_lat_cnt.sv
// Latency counter: loads 1 on request acceptance, increments while waiting,
// flags terminal count at LATENCY-1.
module slow_mem_lat_cnt #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned CNT_W   = $clog2(LATENCY) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(LATENCY - 1));

endmodule

// File: rtl/slow_line_mem.sv
// Behavioural off-chip line memory with fixed request-to-ready latency.
// Optional macro SLOW_MEM_PROTOCOL_CHECK_EN compiles a simulation-only
// protocol checker; functional behaviour is identical either way.
module slow_line_mem
  import slow_mem_pkg::*;
#(
  parameter int unsigned MEM_NUM   = 256,
  parameter int unsigned MEM_WIDTH = LINE_W,
  parameter int unsigned LATENCY   = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [MEM_WIDTH-1:0] mem_wdata,
  output logic [MEM_WIDTH-1:0] mem_rdata,
  output logic                 mem_ready
);

  localparam int unsigned IDX_W = $clog2(MEM_NUM);

  // Storage stays at this level so benches can reach it as <inst>.mem.
  logic [MEM_WIDTH-1:0] mem [MEM_NUM];

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [MEM_WIDTH-1:0] wdata_q;
  logic                 op_wr_q;
  logic                 ready_q;
  logic [MEM_WIDTH-1:0] rdata_q;

  logic req;
  logic accept;
  logic cnt_inc;
  logic cnt_tc;
  logic commit_wr;
  logic commit_rd;
  logic addr_unused;

  assign req         = mem_read | mem_write;
  assign addr_unused = ^mem_addr[ADDR_W-1:IDX_W];

  // Completion happens on the edge that leaves DONE; gating with rst_n keeps
  // a reset on that same edge from committing the write.
  assign commit_wr = rst_n && (state_q == DONE) && op_wr_q;
  assign commit_rd = (state_q == DONE) && !op_wr_q;

  slow_mem_lat_cnt #(
    .LATENCY (LATENCY)
  ) u_lat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .inc_i  (cnt_inc),
    .tc_o   (cnt_tc)
  );

  // Request FSM: accept in IDLE, count in WAIT, abort on request drop.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_tc) begin
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_q == DONE);
      if (commit_rd) begin
        rdata_q <= mem[idx_q];
      end
    end
  end

  // Request capture; write wins when both read and write are high.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= mem_addr[IDX_W-1:0];
      wdata_q <= mem_wdata;
      op_wr_q <= mem_write;
    end
  end

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

`ifdef SLOW_MEM_PROTOCOL_CHECK_EN
  logic [ADDR_W-1:0] chk_addr_q;

  // Full address of the pending request, for change detection.
  always_ff @(posedge clk) begin
    if (accept) begin
      chk_addr_q <= mem_addr;
    end
  end

  // Report requester protocol violations.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (mem_read && mem_write) begin
        $display("ERROR slow_line_mem: read and write both high at %0t", $time);
      end
      if ((state_q != IDLE) && req &&
          ((mem_addr != chk_addr_q) || (op_wr_q && (mem_wdata != wdata_q)))) begin
        $display("ERROR slow_line_mem: addr/wdata changed while pending at %0t", $time);
      end
      if ((state_q == WAIT) && !req) begin
        $display("ERROR slow_line_mem: request dropped before ready at %0t", $time);
      end
    end
  end
`else
  // Protocol checker not compiled.
`endif

endmodule

// File: tb/tb_slow_line_mem.sv
module tb_slow_line_mem;

  localparam int unsigned L = 10;

  logic         clk;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int tests_run = 0;
  int fails     = 0;

  logic [127:0] exp_q[$];
  logic [127:0] model[int];
  logic [127:0] last_rd;

  slow_line_mem #(
    .MEM_NUM   (256),
    .MEM_WIDTH (128),
    .LATENCY   (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a request now and push the expected rdata at its completion.
  task automatic start_req(input logic rd, input logic wr,
                           input logic [27:0] a, input logic [127:0] d);
    int idx;
    idx = int'(a[7:0]);
    if (wr) begin
      model[idx] = d;
      exp_q.push_back(last_rd);
    end else begin
      last_rd = model[idx];
      exp_q.push_back(last_rd);
    end
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  // Count negedges until ready, check latency and scoreboard data.
  task automatic wait_ready(input string nm, input int exp_cyc);
    int cyc;
    logic [127:0] e;
    cyc = 0;
    for (int i = 0; i < 4 * int'(L); i++) begin
      @(negedge clk);
      cyc++;
      if (mem_ready === 1'b1) break;
    end
    if (mem_ready !== 1'b1) cyc = -1;
    tests_run++;
    if (cyc != exp_cyc) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", nm, cyc, exp_cyc);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    tests_run++;
    if (mem_rdata !== e) begin
      fails++;
      $display("FAIL %s rdata: got %h, expected %h", nm, mem_rdata, e);
    end
  endtask

  // Drop the request and check the ready pulse lasted one cycle.
  task automatic finish_pulse(input string nm);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s pulse width: ready got %b, expected 0", nm, mem_ready);
    end
  endtask

  task automatic xact(input string nm, input logic rd, input logic wr,
                      input logic [27:0] a, input logic [127:0] d);
    @(negedge clk);
    start_req(rd, wr, a, d);
    wait_ready(nm, int'(L) + 1);
    finish_pulse(nm);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset ready: got %b, expected 0", mem_ready);
    end
    tests_run++;
    if (mem_rdata !== 128'h0) begin
      fails++;
      $display("FAIL reset rdata: got %h, expected 0", mem_rdata);
    end
    rst_n = 1'b1;
    last_rd = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle ready: got %b, expected 0", mem_ready);
    end
  endtask

  task automatic test_read_basic();
    xact("pre_wr3", 1'b0, 1'b1, 28'd3, {16{8'hA5}});
    xact("rd3", 1'b1, 1'b0, 28'd3, '0);
  endtask

  task automatic test_write_read();
    xact("wr7", 1'b0, 1'b1, 28'd7, 128'h1234);
    xact("rd7", 1'b1, 1'b0, 28'd7, '0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_req(1'b1, 1'b0, 28'd3, '0);
    wait_ready("b2b_first", int'(L) + 1);
    start_req(1'b1, 1'b0, 28'd7, '0);
    wait_ready("b2b_second", int'(L) + 1);
    finish_pulse("b2b");
  endtask

  task automatic test_wrap();
    xact("wr5", 1'b0, 1'b1, 28'd5, 128'h5555_0000_CAFE);
    xact("rd261", 1'b1, 1'b0, 28'd261, '0);
    xact("wr518", 1'b0, 1'b1, 28'd518, 128'h0606_BEEF);
    xact("rd6", 1'b1, 1'b0, 28'd6, '0);
  endtask

  task automatic test_rw_priority();
    xact("rd3_prio", 1'b1, 1'b0, 28'd3, '0);
    xact("rw2", 1'b1, 1'b1, 28'd2, 128'hFF);
    xact("rd2", 1'b1, 1'b0, 28'd2, '0);
  endtask

  task automatic test_abort();
    logic seen;
    xact("wr9", 1'b0, 1'b1, 28'd9, 128'hD00D);
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 28'd9;
    mem_wdata = 128'hEEEE;
    seen = 1'b0;
    repeat (L / 2) begin
      @(negedge clk);
      if (mem_ready === 1'b1) seen = 1'b1;
    end
    mem_write = 1'b0;
    repeat (2 * L) begin
      @(negedge clk);
      if (mem_ready !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort ready: got pulse %b, expected 0", seen);
    end
    xact("rd9", 1'b1, 1'b0, 28'd9, '0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 28'd7;
    mem_wdata = 128'hDEAD;
    repeat (4) @(negedge clk);
    rst_n     = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid ready: got %b, expected 0", mem_ready);
    end
    tests_run++;
    if (mem_rdata !== 128'h0) begin
      fails++;
      $display("FAIL rst_mid rdata: got %h, expected 0", mem_rdata);
    end
    rst_n   = 1'b1;
    last_rd = '0;
    xact("rd7_after_rst", 1'b1, 1'b0, 28'd7, '0);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_rw_priority();
    test_abort();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
